// File: rtl/pipe_stage_skid_reg_if.sv
// Valid/ready stream carrying a control bundle and a data bundle between pipeline stages.
// The master drives valid/ctrl/data, the slave drives ready.
interface pipe_stage_skid_reg_if #(
    parameter int CW = 4,
    parameter int DW = 74
);
    logic          valid;
    logic          ready;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with a two-entry skid buffer, synchronous flush and a
// saturating stall counter. In-side ready comes from a register, never from dn.ready.
module pipe_stage_skid_reg #(
    parameter int CW  = 4,
    parameter int DW  = 74,
    parameter int SCW = 16
) (
    input  logic                            clk,
    input  logic                            clrn,
    input  logic                            flush,
    pipe_stage_skid_reg_if.slave            up,
    pipe_stage_skid_reg_if.master           dn,
    output logic [SCW-1:0]                  stall_cnt
);
    // State bits double as the valid flags: bit 1 = main_v, bit 0 = skid_v.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        TWO   = 2'b11
    } state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  main_ctrl_reg, main_ctrl_next;
    logic [DW-1:0]  main_data_reg, main_data_next;
    logic [CW-1:0]  skid_ctrl_reg, skid_ctrl_next;
    logic [DW-1:0]  skid_data_reg, skid_data_next;
    logic [SCW-1:0] stall_cnt_reg, stall_cnt_next;

    logic main_v;
    logic skid_v;
    logic in_fire;
    logic out_fire;

    assign main_v   = state_reg[1];
    assign skid_v   = state_reg[0];
    assign in_fire  = up.valid & ~skid_v;
    assign out_fire = main_v & dn.ready;

    assign up.ready  = ~skid_v;
    assign dn.valid  = main_v;
    assign dn.ctrl   = main_ctrl_reg;
    assign dn.data   = main_data_reg;
    assign stall_cnt = stall_cnt_reg;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_reg     <= EMPTY;
            main_ctrl_reg <= '0;
            main_data_reg <= '0;
            skid_ctrl_reg <= '0;
            skid_data_reg <= '0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            main_ctrl_reg <= main_ctrl_next;
            main_data_reg <= main_data_next;
            skid_ctrl_reg <= skid_ctrl_next;
            skid_data_reg <= skid_data_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    // Control is zeroed whenever main empties so dn.ctrl never leaks a stale opcode.
    always_comb begin
        state_next     = state_reg;
        main_ctrl_next = main_ctrl_reg;
        main_data_next = main_data_reg;
        skid_ctrl_next = skid_ctrl_reg;
        skid_data_next = skid_data_reg;

        if (flush) begin
            state_next     = EMPTY;
            main_ctrl_next = '0;
            skid_ctrl_next = '0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (in_fire) begin
                        main_ctrl_next = up.ctrl;
                        main_data_next = up.data;
                        state_next     = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_ctrl_next = up.ctrl;
                        main_data_next = up.data;
                    end else if (out_fire) begin
                        main_ctrl_next = '0;
                        state_next     = EMPTY;
                    end else if (in_fire) begin
                        skid_ctrl_next = up.ctrl;
                        skid_data_next = up.data;
                        state_next     = TWO;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_ctrl_next = skid_ctrl_reg;
                        main_data_next = skid_data_reg;
                        state_next     = ONE;
                    end
                end
                default: begin
                    state_next     = EMPTY;
                    main_ctrl_next = '0;
                    skid_ctrl_next = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (main_v && !dn.ready && (stall_cnt_reg != {SCW{1'b1}}))
            stall_cnt_next = stall_cnt_reg + 1'b1;
    end
endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Randomized and directed stimulus for pipe_stage_skid_reg, checked against a
// queue-based model of a two-deep FIFO with flush and a saturating stall count.
module tb_pipe_stage_skid_reg;
    localparam int CW  = 4;
    localparam int DW  = 74;
    localparam int SCW = 4;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic           clk = 1'b0;
    logic           clrn;
    logic           flush;
    logic [SCW-1:0] stall_cnt;

    pipe_stage_skid_reg_if #(.CW(CW), .DW(DW)) up_if ();
    pipe_stage_skid_reg_if #(.CW(CW), .DW(DW)) dn_if ();

    pipe_stage_skid_reg #(.CW(CW), .DW(DW), .SCW(SCW)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .flush     (flush),
        .up        (up_if),
        .dn        (dn_if),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    ent_t          q[$];
    logic [DW-1:0] m_last_data;
    int            m_stall;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last_data = '0;
        m_stall     = 0;
    endtask

    task automatic check_outputs(input string ph);
        logic [CW-1:0] ec;
        logic [DW-1:0] ed;
        ec = (q.size() > 0) ? q[0].c : '0;
        ed = (q.size() > 0) ? q[0].d : m_last_data;
        check({ph, ".out_valid"}, 128'(dn_if.valid), 128'(q.size() > 0));
        check({ph, ".in_ready"},  128'(up_if.ready), 128'(q.size() < 2));
        check({ph, ".out_ctrl"},  128'(dn_if.ctrl),  128'(ec));
        check({ph, ".out_data"},  128'(dn_if.data),  128'(ed));
        check({ph, ".stall_cnt"}, 128'(stall_cnt),   128'(m_stall));
    endtask

    // One clock of stimulus; the model advances on the same edge as the DUT.
    task automatic step(input string ph, input logic v, input logic [CW-1:0] c,
                        input logic [DW-1:0] d, input logic ordy, input logic fl);
        logic in_fire, out_fire;
        ent_t e;
        up_if.valid  = v;
        up_if.ctrl   = c;
        up_if.data   = d;
        dn_if.ready  = ordy;
        flush        = fl;
        in_fire  = v && (q.size() < 2);
        out_fire = (q.size() > 0) && ordy;
        @(posedge clk);
        if (q.size() > 0 && !ordy && m_stall < (1 << SCW) - 1) m_stall++;
        if (out_fire) begin
            $display("%s pop  ctrl=%0h data=%0h", ph, q[0].c, q[0].d);
            void'(q.pop_front());
        end
        if (fl) begin
            if (in_fire) $display("%s drop ctrl=%0h data=%0h (flush)", ph, c, d);
            q.delete();
        end else if (in_fire) begin
            e.c = c;
            e.d = d;
            q.push_back(e);
            $display("%s push ctrl=%0h data=%0h", ph, c, d);
        end
        if (q.size() > 0) m_last_data = q[0].d;
        #1;
        check_outputs(ph);
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    initial begin
        clrn        = 1'b0;
        flush       = 1'b0;
        up_if.valid = 1'b0;
        up_if.ctrl  = '0;
        up_if.data  = '0;
        dn_if.ready = 1'b0;
        model_reset();
        #1;
        check_outputs("reset");
        @(negedge clk);
        clrn = 1'b1;

        // Streaming with downstream always ready.
        step("stream", 1'b1, 4'h1, 74'h1, 1'b1, 1'b0);
        step("stream", 1'b1, 4'h2, 74'h2, 1'b1, 1'b0);
        step("stream", 1'b1, 4'h3, 74'h3, 1'b1, 1'b0);
        step("stream", 1'b0, 4'h0, 74'h0, 1'b1, 1'b0);

        // Back-pressure: fill to two, third push refused, then drain in order.
        step("bp", 1'b1, 4'hA, 74'hA, 1'b0, 1'b0);
        step("bp", 1'b1, 4'hB, 74'hB, 1'b0, 1'b0);
        step("bp", 1'b1, 4'hC, 74'hC, 1'b0, 1'b0);
        check("bp.in_ready_low", 128'(up_if.ready), 128'(0));
        step("bp", 1'b1, 4'hC, 74'hC, 1'b1, 1'b0);
        step("bp", 1'b0, 4'h0, 74'h0, 1'b1, 1'b0);
        step("bp", 1'b0, 4'h0, 74'h0, 1'b1, 1'b0);
        step("bp", 1'b0, 4'h0, 74'h0, 1'b1, 1'b0);

        // Flush from two entries with a push in the same cycle.
        step("flush", 1'b1, 4'hF, 74'h11, 1'b0, 1'b0);
        step("flush", 1'b1, 4'hF, 74'h22, 1'b0, 1'b0);
        step("flush", 1'b1, 4'hD, 74'hDD, 1'b0, 1'b1);
        check("flush.out_ctrl_zero", 128'(dn_if.ctrl), 128'(0));
        step("flush", 1'b0, 4'h0, 74'h0, 1'b1, 1'b0);

        // Simultaneous push and pop while holding one entry.
        step("simul", 1'b1, 4'h5, 74'h55, 1'b0, 1'b0);
        step("simul", 1'b1, 4'h6, 74'h66, 1'b1, 1'b0);
        step("simul", 1'b0, 4'h0, 74'h0, 1'b1, 1'b0);

        // Saturation of the stall counter.
        step("sat", 1'b1, 4'h7, 74'h77, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step("sat", 1'b0, 4'h0, 74'h0, 1'b0, 1'b0);
        check("sat.stall_cnt_max", 128'(stall_cnt), 128'(15));
        step("sat", 1'b0, 4'h0, 74'h0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++)
            step("rand", $urandom_range(0, 9) < 7, 4'($urandom), rand_data(),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);

        // Asynchronous reset mid-cycle with entries held.
        step("prerst", 1'b1, 4'h9, 74'h99, 1'b0, 1'b0);
        step("prerst", 1'b1, 4'h8, 74'h88, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        clrn = 1'b0;
        model_reset();
        #1;
        check_outputs("midrst");
        @(negedge clk);
        clrn = 1'b1;
        step("postrst", 1'b1, 4'h4, 74'h44, 1'b1, 1'b0);
        step("postrst", 1'b0, 4'h0, 74'h0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
